// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//
// Execute stage of the RV32I five-stage pipeline. Selects forwarded
// operands, runs the ALU and latches the result, the store data and the
// memory/write-back control bits into the EX/MEM pipeline register.
//
// Ports
//   clk                    rising-edge clock
//   rst_n                  asynchronous active-low reset, clears every output
//   alu_controller  [3:0]  ALU operation code
//   rs1_data       [31:0]  ID/EX rs1 value
//   rs2_data       [31:0]  ID/EX rs2 value
//   immediate      [31:0]  ID/EX sign-extended immediate
//   pc             [31:0]  ID/EX program counter
//   operand_a_selector     0 = forwarded rs1, 1 = pc
//   operand_b_selector     0 = forwarded rs2, 1 = immediate
//   forward_a/_b    [1:0]  00/11 = register file, 01 = EX/MEM result,
//                          10 = MEM/WB write-back value
//   write_back_data[31:0]  MEM/WB write-back value
//   func_3          [2:0]  load/store width, passed through
//   rd_address      [4:0]  destination register
//   register_write_enable, memory_read, memory_write, instruction_valid
//                          ID/EX control bits
//   stall                  hold the EX/MEM register
//   flush                  turn the EX/MEM slot into a bubble (beats stall)
//   ex_mem_*               registered EX/MEM fields
// -----------------------------------------------------------------------------
module execute_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            alu_controller,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [DATA_WIDTH-1:0] immediate,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  operand_a_selector,
  input  logic                  operand_b_selector,
  input  logic [1:0]            forward_a,
  input  logic [1:0]            forward_b,
  input  logic [DATA_WIDTH-1:0] write_back_data,
  input  logic [2:0]            func_3,
  input  logic [4:0]            rd_address,
  input  logic                  register_write_enable,
  input  logic                  memory_read,
  input  logic                  memory_write,
  input  logic                  instruction_valid,
  input  logic                  stall,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] ex_mem_alu_result,
  output logic [DATA_WIDTH-1:0] ex_mem_store_data,
  output logic [2:0]            ex_mem_func_3,
  output logic [4:0]            ex_mem_rd_address,
  output logic                  ex_mem_register_write,
  output logic                  ex_mem_memory_read,
  output logic                  ex_mem_memory_write,
  output logic                  ex_mem_valid
);

  // ALU operation codes
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b1000;
  localparam logic [3:0] ALU_SLL    = 4'b1010;
  localparam logic [3:0] ALU_SLT    = 4'b1110;
  localparam logic [3:0] ALU_SLTU   = 4'b0001;
  localparam logic [3:0] ALU_XOR    = 4'b0010;
  localparam logic [3:0] ALU_SRL    = 4'b0110;
  localparam logic [3:0] ALU_SRA    = 4'b1001;
  localparam logic [3:0] ALU_OR     = 4'b1100;
  localparam logic [3:0] ALU_AND    = 4'b0100;
  localparam logic [3:0] ALU_PASS_B = 4'b1111;

  // Forwarding select encodings
  localparam logic [1:0] FWD_EX_MEM = 2'b01;
  localparam logic [1:0] FWD_MEM_WB = 2'b10;

  // EX/MEM pipeline register
  logic [DATA_WIDTH-1:0] alu_result_reg;
  logic [DATA_WIDTH-1:0] store_data_reg;
  logic [2:0]            func_3_reg;
  logic [4:0]            rd_address_reg;
  logic                  register_write_reg;
  logic                  memory_read_reg;
  logic                  memory_write_reg;
  logic                  valid_reg;

  // Combinational datapath
  logic [DATA_WIDTH-1:0] forwarded_a;
  logic [DATA_WIDTH-1:0] forwarded_b;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic [4:0]            shift_amount;
  logic [DATA_WIDTH-1:0] alu_result_next;

  // ---------------------------------------------------------------------------
  // Forwarding. Select 01 reads our own EX/MEM result register; while the
  // register is stalled it still holds the producing instruction's result,
  // so a dependent instruction sitting in EX sees a consistent value.
  // ---------------------------------------------------------------------------
  always_comb begin
    forwarded_a = rs1_data;
    case (forward_a)
      FWD_EX_MEM: forwarded_a = alu_result_reg;
      FWD_MEM_WB: forwarded_a = write_back_data;
      default:    forwarded_a = rs1_data;
    endcase
  end

  always_comb begin
    forwarded_b = rs2_data;
    case (forward_b)
      FWD_EX_MEM: forwarded_b = alu_result_reg;
      FWD_MEM_WB: forwarded_b = write_back_data;
      default:    forwarded_b = rs2_data;
    endcase
  end

  assign operand_a    = operand_a_selector ? pc : forwarded_a;
  assign operand_b    = operand_b_selector ? immediate : forwarded_b;
  assign shift_amount = operand_b[4:0];

  // ---------------------------------------------------------------------------
  // ALU. All arithmetic wraps; undefined codes produce zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_result_next = '0;
    case (alu_controller)
      ALU_ADD:    alu_result_next = operand_a + operand_b;
      ALU_SUB:    alu_result_next = operand_a - operand_b;
      ALU_SLL:    alu_result_next = operand_a << shift_amount;
      ALU_SLT:    alu_result_next = {{(DATA_WIDTH-1){1'b0}},
                                     ($signed(operand_a) < $signed(operand_b))};
      ALU_SLTU:   alu_result_next = {{(DATA_WIDTH-1){1'b0}},
                                     (operand_a < operand_b)};
      ALU_XOR:    alu_result_next = operand_a ^ operand_b;
      ALU_SRL:    alu_result_next = operand_a >> shift_amount;
      ALU_SRA:    alu_result_next = DATA_WIDTH'($signed(operand_a) >>> shift_amount);
      ALU_OR:     alu_result_next = operand_a | operand_b;
      ALU_AND:    alu_result_next = operand_a & operand_b;
      ALU_PASS_B: alu_result_next = operand_b;
      default:    alu_result_next = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // EX/MEM register. flush > stall > capture. On flush the data fields are
  // still loaded (they are don't-care in a bubble) and only the control bits
  // are forced low, which keeps the data enables simple.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_reg     <= '0;
      store_data_reg     <= '0;
      func_3_reg         <= '0;
      rd_address_reg     <= '0;
      register_write_reg <= 1'b0;
      memory_read_reg    <= 1'b0;
      memory_write_reg   <= 1'b0;
      valid_reg          <= 1'b0;
    end else if (flush || !stall) begin
      alu_result_reg     <= alu_result_next;
      store_data_reg     <= forwarded_b;
      func_3_reg         <= func_3;
      rd_address_reg     <= rd_address;
      // A non-valid slot is a bubble regardless of its decoded controls.
      register_write_reg <= !flush && instruction_valid && register_write_enable;
      memory_read_reg    <= !flush && instruction_valid && memory_read;
      memory_write_reg   <= !flush && instruction_valid && memory_write;
      valid_reg          <= !flush && instruction_valid;
    end
  end

  assign ex_mem_alu_result     = alu_result_reg;
  assign ex_mem_store_data     = store_data_reg;
  assign ex_mem_func_3         = func_3_reg;
  assign ex_mem_rd_address     = rd_address_reg;
  assign ex_mem_register_write = register_write_reg;
  assign ex_mem_memory_read    = memory_read_reg;
  assign ex_mem_memory_write   = memory_write_reg;
  assign ex_mem_valid          = valid_reg;

endmodule

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
//
// Self-checking bench for execute_stage: a table of ALU vectors with
// hand-computed results, followed by directed sequences for reset,
// forwarding, stall, flush priority and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_execute_stage;

  logic        clk;
  logic        rst_n;
  logic [3:0]  alu_controller;
  logic [31:0] rs1_data, rs2_data, immediate, pc, write_back_data;
  logic        operand_a_selector, operand_b_selector;
  logic [1:0]  forward_a, forward_b;
  logic [2:0]  func_3;
  logic [4:0]  rd_address;
  logic        register_write_enable, memory_read, memory_write;
  logic        instruction_valid, stall, flush;
  logic [31:0] ex_mem_alu_result, ex_mem_store_data;
  logic [2:0]  ex_mem_func_3;
  logic [4:0]  ex_mem_rd_address;
  logic        ex_mem_register_write, ex_mem_memory_read;
  logic        ex_mem_memory_write, ex_mem_valid;

  int n_checks = 0;
  int n_fail   = 0;

  execute_stage #(.DATA_WIDTH(32)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .alu_controller        (alu_controller),
    .rs1_data              (rs1_data),
    .rs2_data              (rs2_data),
    .immediate             (immediate),
    .pc                    (pc),
    .operand_a_selector    (operand_a_selector),
    .operand_b_selector    (operand_b_selector),
    .forward_a             (forward_a),
    .forward_b             (forward_b),
    .write_back_data       (write_back_data),
    .func_3                (func_3),
    .rd_address            (rd_address),
    .register_write_enable (register_write_enable),
    .memory_read           (memory_read),
    .memory_write          (memory_write),
    .instruction_valid     (instruction_valid),
    .stall                 (stall),
    .flush                 (flush),
    .ex_mem_alu_result     (ex_mem_alu_result),
    .ex_mem_store_data     (ex_mem_store_data),
    .ex_mem_func_3         (ex_mem_func_3),
    .ex_mem_rd_address     (ex_mem_rd_address),
    .ex_mem_register_write (ex_mem_register_write),
    .ex_mem_memory_read    (ex_mem_memory_read),
    .ex_mem_memory_write   (ex_mem_memory_write),
    .ex_mem_valid          (ex_mem_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc_v;
    logic        sel_a;
    logic        sel_b;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rwe;
    logic        mr;
    logic        mw;
    logic [31:0] exp_result;
    logic [31:0] exp_store;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " result"}, ex_mem_alu_result, 32'h0);
    check({name, " store"},  ex_mem_store_data, 32'h0);
    check({name, " func3"},  {29'h0, ex_mem_func_3}, 32'h0);
    check({name, " rd"},     {27'h0, ex_mem_rd_address}, 32'h0);
    check({name, " ctrl"},   {28'h0, ex_mem_register_write, ex_mem_memory_read,
                              ex_mem_memory_write, ex_mem_valid}, 32'h0);
  endtask

  // Back to a plain valid ADD with no forwarding, stall or flush.
  task automatic defaults();
    alu_controller        = 4'b0000;
    rs1_data              = '0;
    rs2_data              = '0;
    immediate             = '0;
    pc                    = '0;
    write_back_data       = '0;
    operand_a_selector    = 1'b0;
    operand_b_selector    = 1'b0;
    forward_a             = 2'b00;
    forward_b             = 2'b00;
    func_3                = 3'b000;
    rd_address            = 5'd0;
    register_write_enable = 1'b0;
    memory_read           = 1'b0;
    memory_write          = 1'b0;
    instruction_valid     = 1'b1;
    stall                 = 1'b0;
    flush                 = 1'b0;
  endtask

  // Let the current inputs be clocked in and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // A = 0x8000_0000, B = 4 through the register/forward path
    vecs[0]  = '{4'b0000, 32'h8000_0000, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, 3'd2, 5'd1,  1'b1, 1'b0, 1'b0, 32'h8000_0004, 32'h4};
    vecs[1]  = '{4'b1000, 32'h8000_0000, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 5'd2,  1'b1, 1'b0, 1'b0, 32'h7FFF_FFFC, 32'h4};
    vecs[2]  = '{4'b1010, 32'h8000_0000, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, 3'd1, 5'd3,  1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h4};
    vecs[3]  = '{4'b1110, 32'h8000_0000, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 5'd4,  1'b1, 1'b0, 1'b0, 32'h0000_0001, 32'h4};
    vecs[4]  = '{4'b0001, 32'h8000_0000, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 5'd5,  1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h4};
    vecs[5]  = '{4'b0010, 32'h8000_0000, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, 3'd4, 5'd6,  1'b1, 1'b0, 1'b0, 32'h8000_0004, 32'h4};
    vecs[6]  = '{4'b0110, 32'h8000_0000, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, 3'd5, 5'd7,  1'b1, 1'b0, 1'b0, 32'h0800_0000, 32'h4};
    vecs[7]  = '{4'b1001, 32'h8000_0000, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, 3'd5, 5'd8,  1'b1, 1'b0, 1'b0, 32'hF800_0000, 32'h4};
    vecs[8]  = '{4'b1100, 32'h8000_0000, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, 3'd6, 5'd9,  1'b1, 1'b0, 1'b0, 32'h8000_0004, 32'h4};
    vecs[9]  = '{4'b0100, 32'h8000_0000, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, 3'd7, 5'd10, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h4};
    // PASS_B via immediate path; store data still shows forwarded rs2
    vecs[10] = '{4'b1111, 32'h8000_0000, 32'h4, 32'h4, 32'h0, 1'b0, 1'b1, 3'd0, 5'd11, 1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h4};
    vecs[11] = '{4'b0011, 32'h8000_0000, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 5'd12, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h4};
    vecs[12] = '{4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 3'd2, 5'd13, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h1};
    // pc + immediate (AUIPC-style)
    vecs[13] = '{4'b0000, 32'h1111_1111, 32'hABCD, 32'h20, 32'h100, 1'b1, 1'b1, 3'd3, 5'd31, 1'b1, 1'b0, 1'b0, 32'h0000_0120, 32'hABCD};

    // ---------------- Reset ----------------
    defaults();
    rst_n = 1'b0;
    #2;
    check_all_zero("reset");
    $display("reset: outputs checked while rst_n low");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- Reset then ADD 5+7 ----------------
    defaults();
    rs1_data = 32'd5; rs2_data = 32'd7; rd_address = 5'd3;
    register_write_enable = 1'b1;
    step();
    check("add result", ex_mem_alu_result, 32'd12);
    check("add rd", {27'h0, ex_mem_rd_address}, 32'd3);
    check("add rw", {31'h0, ex_mem_register_write}, 32'd1);
    check("add valid", {31'h0, ex_mem_valid}, 32'd1);
    $display("add 5+7: result=0x%08h", ex_mem_alu_result);

    // ---------------- ALU table ----------------
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      defaults();
      alu_controller        = vecs[i].code;
      rs1_data              = vecs[i].rs1;
      rs2_data              = vecs[i].rs2;
      immediate             = vecs[i].imm;
      pc                    = vecs[i].pc_v;
      operand_a_selector    = vecs[i].sel_a;
      operand_b_selector    = vecs[i].sel_b;
      func_3                = vecs[i].f3;
      rd_address            = vecs[i].rd;
      register_write_enable = vecs[i].rwe;
      memory_read           = vecs[i].mr;
      memory_write          = vecs[i].mw;
      step();
      check($sformatf("vec%0d result", i), ex_mem_alu_result, vecs[i].exp_result);
      check($sformatf("vec%0d store", i), ex_mem_store_data, vecs[i].exp_store);
      check($sformatf("vec%0d func3", i), {29'h0, ex_mem_func_3}, {29'h0, vecs[i].f3});
      check($sformatf("vec%0d rd", i), {27'h0, ex_mem_rd_address}, {27'h0, vecs[i].rd});
      check($sformatf("vec%0d ctrl", i),
            {28'h0, ex_mem_register_write, ex_mem_memory_read, ex_mem_memory_write, ex_mem_valid},
            {28'h0, vecs[i].rwe, vecs[i].mr, vecs[i].mw, 1'b1});
      $display("vec %0d: code=%b result=0x%08h", i, vecs[i].code, ex_mem_alu_result);
    end

    // ---------------- Forwarding back-to-back ----------------
    @(negedge clk);
    defaults();
    rs1_data = 32'd1; rs2_data = 32'd1; register_write_enable = 1'b1;
    step();
    check("fwd0 result", ex_mem_alu_result, 32'd2);
    $display("fwd: 1+1 result=0x%08h", ex_mem_alu_result);

    @(negedge clk);
    defaults();
    forward_a = 2'b01; operand_b_selector = 1'b1; immediate = 32'd3;
    rs1_data = 32'hDEAD_0000;  // must be ignored
    step();
    check("fwd_a 01 result", ex_mem_alu_result, 32'd5);
    $display("fwd: exmem+3 result=0x%08h", ex_mem_alu_result);

    @(negedge clk);
    defaults();
    rs1_data = 32'd1; rs2_data = 32'h0BAD_0000;
    forward_b = 2'b10; write_back_data = 32'd9;
    step();
    check("fwd_b 10 result", ex_mem_alu_result, 32'd10);
    check("fwd_b 10 store", ex_mem_store_data, 32'd9);
    $display("fwd: 1+wb result=0x%08h store=0x%08h", ex_mem_alu_result, ex_mem_store_data);

    // ---------------- Stall ----------------
    @(negedge clk);
    defaults();
    rs1_data = 32'h50; rs2_data = 32'h5; rd_address = 5'd7;
    register_write_enable = 1'b1; func_3 = 3'd2;
    step();
    check("stall pre result", ex_mem_alu_result, 32'h55);

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      defaults();
      stall = 1'b1;
      forward_a = 2'b01; operand_b_selector = 1'b1; immediate = 32'd1;
      rs1_data = 32'h999; rs2_data = 32'h777; rd_address = 5'd9; func_3 = 3'd5;
      register_write_enable = 1'b0; memory_write = 1'b1;
      step();
      check($sformatf("stall%0d result", c), ex_mem_alu_result, 32'h55);
      check($sformatf("stall%0d store", c), ex_mem_store_data, 32'h5);
      check($sformatf("stall%0d rd", c), {27'h0, ex_mem_rd_address}, 32'd7);
      check($sformatf("stall%0d func3", c), {29'h0, ex_mem_func_3}, 32'd2);
      check($sformatf("stall%0d ctrl", c),
            {28'h0, ex_mem_register_write, ex_mem_memory_read, ex_mem_memory_write, ex_mem_valid},
            32'b1001);
      $display("stall cycle %0d: result=0x%08h", c, ex_mem_alu_result);
    end

    @(negedge clk);
    stall = 1'b0;
    step();
    check("stall release result", ex_mem_alu_result, 32'h56);
    check("stall release rd", {27'h0, ex_mem_rd_address}, 32'd9);
    check("stall release ctrl",
          {28'h0, ex_mem_register_write, ex_mem_memory_read, ex_mem_memory_write, ex_mem_valid},
          32'b0011);
    $display("stall released: result=0x%08h", ex_mem_alu_result);

    // ---------------- Flush and priority ----------------
    @(negedge clk);
    defaults();
    rs1_data = 32'h100; immediate = 32'h8; operand_b_selector = 1'b1;
    rs2_data = 32'hCAFE; memory_write = 1'b1; flush = 1'b1;
    step();
    check("flush store ctrl",
          {28'h0, ex_mem_register_write, ex_mem_memory_read, ex_mem_memory_write, ex_mem_valid},
          32'b0000);
    $display("flush store: valid=%0b mw=%0b", ex_mem_valid, ex_mem_memory_write);

    @(negedge clk);
    defaults();
    rs1_data = 32'd2; rs2_data = 32'd2; register_write_enable = 1'b1;
    step();
    check("pre stall+flush valid", {31'h0, ex_mem_valid}, 32'd1);

    @(negedge clk);
    defaults();
    rs1_data = 32'd3; rs2_data = 32'd3; register_write_enable = 1'b1;
    memory_read = 1'b1; stall = 1'b1; flush = 1'b1;
    step();
    check("stall+flush ctrl",
          {28'h0, ex_mem_register_write, ex_mem_memory_read, ex_mem_memory_write, ex_mem_valid},
          32'b0000);
    $display("stall+flush: valid=%0b rw=%0b", ex_mem_valid, ex_mem_register_write);

    @(negedge clk);
    defaults();
    instruction_valid = 1'b0; register_write_enable = 1'b1; memory_read = 1'b1;
    rs1_data = 32'd3; rs2_data = 32'd4; rd_address = 5'd17;
    step();
    check("invalid ctrl",
          {28'h0, ex_mem_register_write, ex_mem_memory_read, ex_mem_memory_write, ex_mem_valid},
          32'b0000);
    check("invalid data result", ex_mem_alu_result, 32'd7);
    check("invalid data rd", {27'h0, ex_mem_rd_address}, 32'd17);
    $display("invalid slot: rw=%0b result=0x%08h", ex_mem_register_write, ex_mem_alu_result);

    // ---------------- Async reset mid-stall ----------------
    @(negedge clk);
    defaults();
    rs1_data = 32'h1200; rs2_data = 32'h34; rd_address = 5'd21; func_3 = 3'd1;
    register_write_enable = 1'b1;
    step();
    check("pre areset result", ex_mem_alu_result, 32'h1234);

    @(negedge clk);
    stall = 1'b1;
    step();
    check("areset hold result", ex_mem_alu_result, 32'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("areset low");
    $display("async reset: outputs checked between edges");
    @(negedge clk);
    rst_n = 1'b1;
    step();  // stall still high: nothing may reappear
    check_all_zero("areset after");
    @(negedge clk);
    stall = 1'b0;
    step();
    check("areset recapture result", ex_mem_alu_result, 32'h1234);
    check("areset recapture valid", {31'h0, ex_mem_valid}, 32'd1);
    $display("post reset capture: result=0x%08h", ex_mem_alu_result);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the RV32I 5-stage pipelined CPU. It consumes the 4-bit ALU control code from the ALU controller and the ID/EX operands. It applies hazard-unit forwarding, computes the ALU result, and registers the result and the memory/write-back control into the EX/MEM pipeline register, with stall and flush support.

## Interface
Parameters:
- DATA_WIDTH, 32, operand and result width (RV32I; only 32 is supported).

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- alu_controller  input  4  ALU operation code from the ALU controller.
- rs1_data  input  32  ID/EX rs1 value.
- rs2_data  input  32  ID/EX rs2 value.
- immediate  input  32  ID/EX sign-extended immediate.
- pc  input  32  ID/EX program counter.
- operand_a_selector  input  1  selects operand A: 0 = forwarded rs1, 1 = pc.
- operand_b_selector  input  1  selects operand B: 0 = forwarded rs2, 1 = immediate.
- forward_a  input  2  rs1 forwarding select: 00 = rs1_data, 01 = ex_mem_alu_result, 10 = write_back_data, 11 = rs1_data.
- forward_b  input  2  rs2 forwarding select, same encoding as forward_a.
- write_back_data  input  32  MEM/WB write-back value.
- func_3  input  3  ID/EX func_3, passed through for load/store width.
- rd_address  input  5  destination register.
- register_write_enable  input  1  ID/EX register write.
- memory_read  input  1  ID/EX load.
- memory_write  input  1  ID/EX store.
- instruction_valid  input  1  ID/EX slot holds a real instruction.
- stall  input  1  hazard unit: hold the EX/MEM register.
- flush  input  1  hazard unit: insert a bubble into EX/MEM.
- ex_mem_alu_result  output  32  registered ALU result.
- ex_mem_store_data  output  32  registered forwarded rs2, used as store data.
- ex_mem_func_3  output  3  registered func_3.
- ex_mem_rd_address  output  5  registered rd.
- ex_mem_register_write  output  1  registered register write.
- ex_mem_memory_read  output  1  registered load.
- ex_mem_memory_write  output  1  registered store.
- ex_mem_valid  output  1  registered valid.

## Operation
- Forwarding:
  - fa is rs1 after forward_a; fb is rs2 after forward_b.
  - Forward select 01 takes this block's own ex_mem_alu_result register.
- Operand muxes:
  - A = operand_a_selector ? pc : fa.
  - B = operand_b_selector ? immediate : fb.
- ALU codes (shift amount is B[4:0]):
  - 0000 ADD: A+B, mod 2^32.
  - 1000 SUB: A−B, mod 2^32.
  - 1010 SLL: A << B[4:0].
  - 1110 SLT: signed A<B, result 1/0.
  - 0001 SLTU: unsigned A<B, result 1/0.
  - 0010 XOR: A^B.
  - 0110 SRL: logical A >> B[4:0].
  - 1001 SRA: arithmetic A >> B[4:0].
  - 1100 OR: A|B.
  - 0100 AND: A&B.
  - 1111 PASS_B: B (LUI).
  - Any other code gives result 0.
- ALU and muxes are combinational. Only the EX/MEM register is sequential.
- Control gating: when instruction_valid=0, the captured register_write, memory_read, memory_write and valid are 0. Data fields are still captured.

## Timing
- Reset (rst_n=0): all outputs go to 0 immediately and asynchronously and stay 0 until the first rising edge after deassertion.
- Latency: inputs are presented in cycle N and the result appears on the ex_mem_* outputs after the rising edge ending cycle N. Latency is 1 cycle and throughput is 1 instruction per cycle.
- Priority at each rising edge is flush > stall > capture:
  - flush=1: ex_mem_valid, ex_mem_register_write, ex_mem_memory_read and ex_mem_memory_write clear to 0. Data fields are captured normally and are don't-care.
  - stall=1, flush=0: every ex_mem_* output holds its value.
  - Otherwise: all fields capture the new values.
- Simultaneous stall and flush: flush wins and a bubble is produced.
- Forwarding during stall: forward select 01 reads the held ex_mem_alu_result, so results stay consistent across the stall.
- Reset asserted mid-stall or mid-flush: outputs clear at once. No pending state survives reset.
- Arithmetic wraps silently. No overflow flags.

## Test plan
- Reset then ADD: rst_n low gives all outputs 0. Then A=rs1=5, B=rs2=7, code 0000, register_write_enable=1, rd=3, valid=1. Next edge: ex_mem_alu_result=12, rd=3, register_write=1, valid=1.
- Every ALU code with A=0x8000_0000, B=0x0000_0004:
  - SUB=0x7FFF_FFFC.
  - SLL=0.
  - SLT=1, SLTU=0.
  - SRL=0x0800_0000, SRA=0xF800_0000.
  - PASS_B=4.
  - Code 0011 gives 0.
  - ADD of 0xFFFF_FFFF+1 gives 0.
- Forwarding back-to-back: ADD 1+1 gives 2. Next instruction uses forward_a=01 with ADD immediate 3, giving 5. forward_b=10 with write_back_data=9, operand_b_selector=0, ADD with rs1=1 gives 10, and ex_mem_store_data=9.
- Stall: capture result 0x55, then assert stall with different inputs for 3 cycles. Outputs hold 0x55 and its controls, and forward 01 during the stall still uses 0x55. Release the stall and the next edge captures the new result.
- Flush and priority: a store instruction with flush=1 gives ex_mem_memory_write=0, register_write=0, valid=0. stall=1 together with flush=1 also gives a bubble. instruction_valid=0 with register_write_enable=1 gives ex_mem_register_write=0.
- Async reset mid-stream: pulse rst_n low between edges while valid data is held. All outputs drop to 0 before the next edge.
